pw_conv_seq: RTL and testbench

- Hardware sequencer for one output pixel of a 1x1 (pointwise) convolution.
- Reads int8 weights, int8 activations and int32 biases from synchronous buffers, then drives the existing mac_int8, leaky_relu and requantize units through their valid/done handshakes.
- Emits one int8 result per output channel on a ready/valid stream.
- Replaces the software-style driver loop with synthesizable control in front of the layer-7 datapath.

---
 rtl/pw_conv_seq.sv | 203 ++++++++++++++++++++
 tb/tb_pw_conv_seq.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pw_conv_seq.sv
// Sequencer for one output pixel of a pointwise (1x1) convolution.
// It drives the mac_int8, leaky_relu and requantize units. Define PWSEQ_BIAS_SAT_EN to saturate the acc+bias add.
module pw_conv_seq #(
    parameter int MACS_PER_CH = 64,
    parameter int NUM_CH      = 4,
    parameter int WA_W        = $clog2(NUM_CH * MACS_PER_CH),
    parameter int AA_W        = (MACS_PER_CH > 1) ? $clog2(MACS_PER_CH) : 1,
    parameter int CA_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       scale,
    output logic              busy,
    output logic              done,
    output logic              w_rd_en,
    output logic [WA_W-1:0]   w_addr,
    input  logic [7:0]        w_rdata,
    output logic              a_rd_en,
    output logic [AA_W-1:0]   a_addr,
    input  logic [7:0]        a_rdata,
    output logic              b_rd_en,
    output logic [CA_W-1:0]   b_addr,
    input  logic [31:0]       b_rdata,
    output logic              mac_valid,
    output logic [7:0]        mac_weight,
    output logic [7:0]        mac_act,
    output logic [31:0]       mac_acc_in,
    input  logic [31:0]       mac_acc_out,
    input  logic              mac_done,
    output logic              lk_valid,
    output logic [31:0]       lk_x,
    input  logic [31:0]       lk_y,
    input  logic              lk_done,
    output logic              rq_valid,
    output logic [31:0]       rq_acc,
    output logic [15:0]       rq_scale,
    input  logic [7:0]        rq_out,
    input  logic              rq_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [CA_W-1:0]   out_ch
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_MWAIT, S_BIAS,
        S_LK, S_LWAIT, S_RQ, S_RWAIT, S_OUT
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CA_W-1:0]   r_ch;
    logic [AA_W-1:0]   r_i;
    logic [31:0]       r_acc;
    logic [15:0]       r_scale;
    logic [7:0]        r_mac_w;
    logic [7:0]        r_mac_a;
    logic [31:0]       r_lk_x;
    logic [31:0]       r_rq_acc;
    logic [7:0]        r_out_data;
    logic [CA_W-1:0]   r_out_ch;
    logic              r_done;

    logic              w_last_mac;
    logic              w_last_ch;
    logic              w_start_ok;
    logic [31:0]       w_biased;

    assign w_last_mac = (r_i == AA_W'(MACS_PER_CH - 1));
    assign w_last_ch  = (r_ch == CA_W'(NUM_CH - 1));
    // A start landing on the done cycle belongs to the finished pixel and is dropped.
    assign w_start_ok = start && !r_done;

`ifdef PWSEQ_BIAS_SAT_EN
    logic signed [32:0] w_sum_ext;
    assign w_sum_ext = $signed({r_acc[31], r_acc}) + $signed({b_rdata[31], b_rdata});
    always_comb begin
        w_biased = w_sum_ext[31:0];
        if (w_sum_ext[32] != w_sum_ext[31])
            w_biased = w_sum_ext[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
`else
    assign w_biased = r_acc + b_rdata;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_state_next = S_FETCH;
            S_FETCH: w_state_next = S_ISSUE;
            S_ISSUE: w_state_next = S_MWAIT;
            S_MWAIT: if (mac_done) w_state_next = w_last_mac ? S_BIAS : S_FETCH;
            S_BIAS:  w_state_next = S_LK;
            S_LK:    w_state_next = S_LWAIT;
            S_LWAIT: if (lk_done) w_state_next = S_RQ;
            S_RQ:    w_state_next = S_RWAIT;
            S_RWAIT: if (rq_done) w_state_next = S_OUT;
            S_OUT:   if (out_ready) w_state_next = w_last_ch ? S_IDLE : S_FETCH;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch       <= '0;
            r_i        <= '0;
            r_acc      <= '0;
            r_scale    <= '0;
            r_mac_w    <= '0;
            r_mac_a    <= '0;
            r_lk_x     <= '0;
            r_rq_acc   <= '0;
            r_out_data <= '0;
            r_out_ch   <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (w_start_ok) begin
                    r_scale <= scale;
                    r_ch    <= '0;
                    r_i     <= '0;
                    r_acc   <= '0;
                end
                // Operands captured here keep the MAC inputs stable until mac_done.
                S_ISSUE: begin
                    r_mac_w <= w_rdata;
                    r_mac_a <= a_rdata;
                end
                S_MWAIT: if (mac_done) begin
                    r_acc <= mac_acc_out;
                    if (!w_last_mac) r_i <= r_i + AA_W'(1);
                end
                S_LK:    r_lk_x <= w_biased;
                S_LWAIT: if (lk_done) r_rq_acc <= lk_y;
                S_RWAIT: if (rq_done) begin
                    r_out_data <= rq_out;
                    r_out_ch   <= r_ch;
                end
                S_OUT: if (out_ready) begin
                    if (w_last_ch) begin
                        r_done <= 1'b1;
                    end else begin
                        r_ch  <= r_ch + CA_W'(1);
                        r_i   <= '0;
                        r_acc <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rd_en    = 1'b0;
        a_rd_en    = 1'b0;
        b_rd_en    = 1'b0;
        mac_valid  = 1'b0;
        lk_valid   = 1'b0;
        rq_valid   = 1'b0;
        out_valid  = 1'b0;
        mac_weight = r_mac_w;
        mac_act    = r_mac_a;
        lk_x       = r_lk_x;
        case (r_state)
            S_FETCH: begin
                w_rd_en = 1'b1;
                a_rd_en = 1'b1;
            end
            S_ISSUE: begin
                mac_valid  = 1'b1;
                mac_weight = w_rdata;
                mac_act    = a_rdata;
            end
            S_BIAS: b_rd_en = 1'b1;
            S_LK: begin
                lk_valid = 1'b1;
                lk_x     = w_biased;
            end
            S_RQ:  rq_valid  = 1'b1;
            S_OUT: out_valid = 1'b1;
            default: ;
        endcase
    end

    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign w_addr     = WA_W'(32'(r_ch) * 32'(MACS_PER_CH) + 32'(r_i));
    assign a_addr     = r_i;
    assign b_addr     = r_ch;
    assign mac_acc_in = r_acc;
    assign rq_acc     = r_rq_acc;
    assign rq_scale   = r_scale;
    assign out_data   = r_out_data;
    assign out_ch     = r_out_ch;

endmodule

// File: tb/tb_pw_conv_seq.sv
// Randomized bench for pw_conv_seq: models buffers and sub-units and predicts every channel
// result from weights, activations, biases and scale with plain arithmetic.
`timescale 1ns/1ps
module tb_pw_conv_seq;
    localparam int M = 64;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst, start;
    logic [15:0] scale;
    logic busy, done, w_rd_en, a_rd_en, b_rd_en;
    logic [7:0] w_addr;
    logic [5:0] a_addr;
    logic [1:0] b_addr;
    logic signed [7:0]  w_rdata = '0, a_rdata = '0;
    logic signed [31:0] b_rdata = '0;
    logic mac_valid;
    logic signed [7:0]  mac_weight, mac_act;
    logic signed [31:0] mac_acc_in;
    logic signed [31:0] mac_acc_out = '0;
    logic mac_done = 1'b0;
    logic lk_valid;
    logic signed [31:0] lk_x;
    logic signed [31:0] lk_y = '0;
    logic lk_done = 1'b0;
    logic rq_valid;
    logic signed [31:0] rq_acc;
    logic [15:0] rq_scale;
    logic signed [7:0] rq_out = '0;
    logic rq_done = 1'b0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic signed [7:0] out_data;
    logic [1:0] out_ch;

    always #5 clk = ~clk;

    pw_conv_seq dut (
        .clk(clk), .rst(rst), .start(start), .scale(scale), .busy(busy), .done(done),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata),
        .a_rd_en(a_rd_en), .a_addr(a_addr), .a_rdata(a_rdata),
        .b_rd_en(b_rd_en), .b_addr(b_addr), .b_rdata(b_rdata),
        .mac_valid(mac_valid), .mac_weight(mac_weight), .mac_act(mac_act),
        .mac_acc_in(mac_acc_in), .mac_acc_out(mac_acc_out), .mac_done(mac_done),
        .lk_valid(lk_valid), .lk_x(lk_x), .lk_y(lk_y), .lk_done(lk_done),
        .rq_valid(rq_valid), .rq_acc(rq_acc), .rq_scale(rq_scale), .rq_out(rq_out), .rq_done(rq_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch)
    );

    // Pixel data and bench state
    logic signed [7:0]  W [N*M];
    logic signed [7:0]  A [M];
    logic signed [31:0] B [N];
    logic signed [31:0] INJ [N];   // extra term the MAC model adds on a channel's first MAC
    logic signed [31:0] obs_lkx [N];
    logic signed [7:0]  obs_out [N];
    logic signed [31:0] last_accin;
    logic [15:0] cur_scale;
    int nvec = 0, nerr = 0;
    int n_issue = 0, n_out = 0, done_cnt = 0, busy_cyc = 0, stall_cnt = 0;
    int ready_mode = 0, maxlat = 0;
    bit spur = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic signed [31:0] leaky(input logic signed [31:0] x);
        return (x < 0) ? (x >>> 3) : x;
    endfunction

    function automatic logic signed [7:0] requant(input logic signed [31:0] y, input logic [15:0] s);
        longint p;
        p = (longint'(y) * longint'(s)) >>> 16;
        if (p > 127) p = 127;
        if (p < -128) p = -128;
        return 8'(p);
    endfunction

    function automatic logic signed [31:0] exp_acc(input int ch, input int i);
        logic signed [31:0] s;
        s = (i > 0) ? INJ[ch] : 32'sd0;
        for (int k = 0; k < i; k++) s = s + W[ch*M+k] * A[k];
        return s;
    endfunction

    function automatic logic signed [31:0] exp_x(input int ch);
        longint s;
        s = longint'(exp_acc(ch, M)) + longint'(B[ch]);
`ifdef PWSEQ_BIAS_SAT_EN
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
        return 32'(s);
    endfunction

    // Buffers: data appears one cycle after the read enable, junk otherwise.
    bit w_pend = 0, a_pend = 0, b_pend = 0;
    logic [7:0] w_pa; logic [5:0] a_pa; logic [1:0] b_pa;
    always @(posedge clk) begin
        #1;
        w_rdata = w_pend ? W[w_pa] : 8'($urandom);
        a_rdata = a_pend ? A[a_pa] : 8'($urandom);
        b_rdata = b_pend ? B[b_pa] : $urandom;
    end

    // Sub-unit responders, output stream sink and monitors, all at the falling edge.
    bit m_pend = 0, l_pend = 0, r_pend = 0, p_ov = 0, p_or = 0;
    int m_lat, l_lat, r_lat;
    logic signed [7:0]  m_w, m_a, p_od;
    logic signed [31:0] m_acc, m_inj, l_x, r_acc;
    logic [15:0] r_sc;
    logic [1:0] p_oc;
    always @(negedge clk) begin
        w_pend = w_rd_en; w_pa = w_addr;
        a_pend = a_rd_en; a_pa = a_addr;
        b_pend = b_rd_en; b_pa = b_addr;
        mac_done = 0; lk_done = 0; rq_done = 0;
        if (rst) begin
            m_pend = 0; l_pend = 0; r_pend = 0; p_ov = 0; out_ready = 1;
        end else begin
            if (busy) busy_cyc++;
            if (w_rd_en) begin
                chk("w_addr", w_addr, n_issue);
                chk("a_addr", a_addr, n_issue % M);
            end
            if (b_rd_en) chk("b_addr", b_addr, n_out);
            // MAC
            if (m_pend) begin
                chk("mac_valid_pulse", mac_valid, 0);
                chk("mac_hold", {mac_weight, mac_act, mac_acc_in}, {m_w, m_a, m_acc});
                if (m_lat == 0) begin
                    mac_done = 1; mac_acc_out = m_acc + m_w * m_a + m_inj; m_pend = 0;
                end else m_lat--;
            end else if (mac_valid) begin
                chk("one_outstanding", {l_pend, r_pend}, 0);
                if (n_issue < N*M) begin
                    chk("mac_weight", mac_weight, W[n_issue]);
                    chk("mac_act", mac_act, A[n_issue % M]);
                    chk("mac_acc_in", mac_acc_in, exp_acc(n_issue / M, n_issue % M));
                    m_inj = (n_issue % M == 0) ? INJ[n_issue / M] : 32'sd0;
                end else chk("extra_mac", 1, 0);
                last_accin = mac_acc_in;
                m_pend = 1; m_w = mac_weight; m_a = mac_act; m_acc = mac_acc_in;
                m_lat = $urandom_range(0, maxlat); n_issue++;
            end else if (spur && $urandom_range(0, 7) == 0) begin
                mac_done = 1; mac_acc_out = $urandom;
            end
            // LeakyReLU
            if (l_pend) begin
                chk("lk_hold", {lk_valid, lk_x}, {1'b0, l_x});
                if (l_lat == 0) begin lk_done = 1; lk_y = leaky(l_x); l_pend = 0; end
                else l_lat--;
            end else if (lk_valid) begin
                chk("one_outstanding", {m_pend, r_pend}, 0);
                chk("lk_x", lk_x, exp_x(n_out % N));
                obs_lkx[n_out % N] = lk_x;
                l_pend = 1; l_x = lk_x; l_lat = $urandom_range(0, maxlat);
            end else if (spur && $urandom_range(0, 7) == 0) begin
                lk_done = 1; lk_y = $urandom;
            end
            // Requantize
            if (r_pend) begin
                chk("rq_hold", {rq_valid, rq_acc, rq_scale}, {1'b0, r_acc, r_sc});
                if (r_lat == 0) begin rq_done = 1; rq_out = requant(r_acc, r_sc); r_pend = 0; end
                else r_lat--;
            end else if (rq_valid) begin
                chk("one_outstanding", {m_pend, l_pend}, 0);
                chk("rq_acc", rq_acc, leaky(exp_x(n_out % N)));
                chk("rq_scale", rq_scale, cur_scale);
                r_pend = 1; r_acc = rq_acc; r_sc = rq_scale; r_lat = $urandom_range(0, maxlat);
            end else if (spur && $urandom_range(0, 7) == 0) begin
                rq_done = 1; rq_out = 8'($urandom);
            end
            // Output stream
            if (p_ov && !p_or)
                chk("out_hold", {out_valid, out_data, out_ch}, {1'b1, p_od, p_oc});
            if (out_valid)
                chk("quiet_in_out", {w_rd_en, a_rd_en, b_rd_en, mac_valid, lk_valid, rq_valid}, 0);
            case (ready_mode)
                0: out_ready = 1;
                1: out_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    if (out_valid && out_ch == 2 && stall_cnt < 20) begin
                        out_ready = 0; stall_cnt++;
                    end else out_ready = 1;
                end
            endcase
            if (out_valid && out_ready) begin
                chk("out_ch", out_ch, n_out % N);
                chk("out_data", out_data, requant(leaky(exp_x(n_out % N)), cur_scale));
                obs_out[n_out % N] = out_data;
                n_out++;
            end
            if (done) begin
                chk("done_after_last", n_out, N);
                done_cnt++;
            end
            p_ov = out_valid; p_or = out_ready; p_od = out_data; p_oc = out_ch;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk_reset();
        chk("rst_ctrl", {busy, done, w_rd_en, a_rd_en, b_rd_en, mac_valid, lk_valid, rq_valid, out_valid}, 0);
        chk("rst_addr", {w_addr, a_addr, b_addr}, 0);
        chk("rst_mac", {mac_weight, mac_act, mac_acc_in}, 0);
        chk("rst_lk_rq", {lk_x, rq_acc}, 0);
        chk("rst_out", {rq_scale, out_data, out_ch}, 0);
    endtask

    task automatic fill_random(input bit with_inj);
        foreach (W[k]) W[k] = 8'($urandom);
        foreach (A[k]) A[k] = 8'($urandom);
        foreach (B[c]) begin
            B[c]   = $urandom;
            INJ[c] = with_inj ? $urandom : 0;
        end
    endtask

    task automatic run_pixel(input bit mid_start, input bit sod);
        bit got = 0, sent = 0;
        n_issue = 0; n_out = 0; done_cnt = 0; busy_cyc = 0;
        cur_scale = scale;
        start = 1; tick; start = 0;
        for (int t = 0; t < 20000 && !got; t++) begin
            tick; start = 0;
            if (done) begin
                got = 1;
                if (sod) start = 1;
            end else if (mid_start && !sent && n_issue >= 1) begin
                start = 1; sent = 1;
            end
        end
        if (!got) chk("done_timeout", 0, 1);
        tick; start = 0;
        repeat (3) tick;
        chk("outputs", n_out, N);
        chk("done_count", done_cnt, 1);
        chk("idle_after_done", busy, 0);
    endtask

    initial begin
        rst = 1; start = 0; scale = 0;
        foreach (W[k]) W[k] = 0;
        foreach (A[k]) A[k] = 0;
        foreach (B[c]) begin B[c] = 0; INJ[c] = 0; end
        repeat (3) tick;
        chk_reset();
        rst = 0; tick;

        // Unit data, zero-latency sub-units: exact cycle count and literal results
        foreach (W[k]) W[k] = 1;
        foreach (A[k]) A[k] = 1;
        scale = 16'd32768; maxlat = 0; spur = 0; ready_mode = 0;
        run_pixel(0, 0);
        chk("busy_cycles", busy_cyc, 4 * (3 * M + 6));
        chk("lit_lkx_ch0", obs_lkx[0], 64);
        chk("lit_lkx_ch3", obs_lkx[3], 64);
        chk("lit_out_ch2", obs_out[2], 32);
        chk("lit_last_accin", last_accin, 63);

        // Negative channel-1 weights with bias 100
        fill_random(0);
        for (int k = M; k < 2*M; k++) W[k] = -1;
        foreach (A[k]) A[k] = 2;
        B[1] = 100;
        scale = 16'd32768; maxlat = 3; spur = 1; ready_mode = 1;
        run_pixel(0, 0);
        chk("lit_lkx_ch1", obs_lkx[1], -28);
        chk("lit_out_ch1", obs_out[1], -2);

        // 20-cycle output stall on channel 2
        fill_random(0);
        scale = 16'($urandom); ready_mode = 2; stall_cnt = 0;
        run_pixel(0, 0);
        chk("stall_cycles", stall_cnt, 20);

        // Start pulses while busy: during ch0 MWAIT and on the done cycle
        fill_random(0);
        scale = 16'($urandom); ready_mode = 1;
        run_pixel(1, 1);

        // Reset in the middle of ch1, MAC 30, then a clean restart
        fill_random(0);
        scale = 16'($urandom);
        n_issue = 0; n_out = 0; cur_scale = scale;
        start = 1; tick; start = 0;
        for (int t = 0; t < 5000 && n_issue < M + 31; t++) tick;
        chk("reach_mid_mac", n_issue, M + 31);
        rst = 1; tick;
        chk_reset();
        rst = 0; tick;
        run_pixel(0, 0);

        // Bias add at the positive edge of the 32-bit range
        fill_random(0);
        foreach (W[k]) W[k] = 0;
        INJ[0] = 32'h7FFF_FFF0; B[0] = 32'h20;
        scale = 16'($urandom);
        run_pixel(0, 0);
`ifdef PWSEQ_BIAS_SAT_EN
        chk("lit_bias_edge", obs_lkx[0], 32'sh7FFF_FFFF);
`else
        chk("lit_bias_edge", obs_lkx[0], 32'sh8000_0010);
`endif

        // Fully random pixels with large accumulator offsets
        maxlat = 4;
        for (int r = 0; r < 3; r++) begin
            fill_random(1);
            scale = 16'($urandom);
            run_pixel(0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
